// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-serial memory controller.
// Holds the FSM state encoding, access size codes and the stalling I/O addresses.
package mem_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_SIZE  = 16;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE
  } state_e;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  localparam logic [XLEN-1:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [XLEN-1:0] IO_ADDR_1 = 32'h0003_0004;

  // Any size code that is not a byte or half access moves a full word.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_BYTE: return SIZE_BYTE;
      SIZE_HALF: return SIZE_HALF;
      default:   return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle of mem_ctrl.
// MEM_IO_STALL_EN adds io_buffer_full for stalling stores to the I/O addresses.
interface mem_ctrl_if #(
  parameter int unsigned RAM_ADDR_W = 17
) ();
  import mem_ctrl_pkg::*;

  logic                  ena;
  logic                  in_rollback;
  logic                  in_if_ena;
  logic [XLEN-1:0]       in_if_addr;
  logic                  out_if_ready;
  logic [XLEN-1:0]       out_if_data;
  logic                  in_ls_ena;
  logic                  in_ls_iswrite;
  logic [XLEN-1:0]       in_ls_addr;
  logic [2:0]            in_ls_size;
  logic [XLEN-1:0]       in_ls_wdata;
  logic                  out_ls_ready;
  logic [XLEN-1:0]       out_ls_data;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_wr;
`ifdef MEM_IO_STALL_EN
  logic                  io_buffer_full;
`endif

  modport slave (
`ifdef MEM_IO_STALL_EN
    input  io_buffer_full,
`endif
    input  ena, in_rollback,
    input  in_if_ena, in_if_addr,
    input  in_ls_ena, in_ls_iswrite, in_ls_addr, in_ls_size, in_ls_wdata,
    input  ram_din,
    output out_if_ready, out_if_data, out_ls_ready, out_ls_data,
    output ram_dout, ram_addr, ram_wr
  );

  modport master (
`ifdef MEM_IO_STALL_EN
    output io_buffer_full,
`endif
    output ena, in_rollback,
    output in_if_ena, in_if_addr,
    output in_ls_ena, in_ls_iswrite, in_ls_addr, in_ls_size, in_ls_wdata,
    output ram_din,
    input  out_if_ready, out_if_data, out_ls_ready, out_ls_data,
    input  ram_dout, ram_addr, ram_wr
  );

endinterface

// File: rtl/mem_req_slot.sv
// One pending-request register for a requester of mem_ctrl.
// A set in the same cycle as a clear keeps the new request.
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ena_i,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [2:0]      size_i,
  input  logic            iswrite_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] addr_o,
  output logic [2:0]      size_o,
  output logic            iswrite_o,
  output logic [XLEN-1:0] wdata_o
);

  logic            valid_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      size_q;
  logic            iswrite_q;
  logic [XLEN-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      iswrite_q <= 1'b0;
      wdata_q   <= '0;
    end else if (ena_i) begin
      if (set_i) begin
        valid_q   <= 1'b1;
        addr_q    <= addr_i;
        size_q    <= size_i;
        iswrite_q <= iswrite_i;
        wdata_q   <= wdata_i;
      end else if (clr_i) begin
        valid_q   <= 1'b0;
      end
    end
  end

  assign valid_o   = valid_q;
  assign addr_o    = addr_q;
  assign size_o    = size_q;
  assign iswrite_o = iswrite_q;
  assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSQ accesses.
// Optional MEM_IO_STALL_EN holds stores to the I/O addresses while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 17
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_e          state_q;
  logic [2:0]      cnt_q, len_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic            if_ready_q, ls_ready_q;
  logic [XLEN-1:0] if_data_q, ls_data_q;

  logic            f_valid, f_iswrite, l_valid, l_iswrite;
  logic [XLEN-1:0] f_addr, f_wdata, l_addr, l_wdata;
  logic [2:0]      f_size, l_size;
  logic            rb, idle, f_go, l_go, f_set, l_set, f_clr, l_clr;
  logic            sel_iswrite, rd_act, st_act, stall;
  logic [XLEN-1:0] sel_addr, sel_wdata;
  logic [2:0]      sel_size;
  logic [1:0]      lane;

  // A rollback drops same-cycle and pending fetches/loads; stores always survive.
  assign rb    = bus.in_rollback;
  assign idle  = (state_q == S_IDLE);
  assign l_go  = idle && l_valid && !(rb && !l_iswrite);
  assign f_go  = idle && !l_go && f_valid && !rb;
  assign f_set = bus.in_if_ena && !rb;
  assign l_set = bus.in_ls_ena && (!rb || bus.in_ls_iswrite);
  assign f_clr = rb || f_go;
  assign l_clr = (rb && !l_iswrite) || l_go;

  mem_req_slot u_fetch_slot (
    .clk(clk), .rst(rst), .ena_i(bus.ena), .set_i(f_set), .clr_i(f_clr),
    .addr_i(bus.in_if_addr), .size_i(SIZE_WORD), .iswrite_i(1'b0), .wdata_i('0),
    .valid_o(f_valid), .addr_o(f_addr), .size_o(f_size), .iswrite_o(f_iswrite),
    .wdata_o(f_wdata)
  );

  mem_req_slot u_ls_slot (
    .clk(clk), .rst(rst), .ena_i(bus.ena), .set_i(l_set), .clr_i(l_clr),
    .addr_i(bus.in_ls_addr), .size_i(bus.in_ls_size), .iswrite_i(bus.in_ls_iswrite),
    .wdata_i(bus.in_ls_wdata),
    .valid_o(l_valid), .addr_o(l_addr), .size_o(l_size), .iswrite_o(l_iswrite),
    .wdata_o(l_wdata)
  );

  assign sel_addr    = l_go ? l_addr    : f_addr;
  assign sel_size    = l_go ? l_size    : f_size;
  assign sel_iswrite = l_go ? l_iswrite : f_iswrite;
  assign sel_wdata   = l_go ? l_wdata   : f_wdata;

`ifdef MEM_IO_STALL_EN
  assign stall = bus.io_buffer_full && ((addr_q == IO_ADDR_0) || (addr_q == IO_ADDR_1));
`else
  assign stall = 1'b0;
`endif

  // RAM bus is a pure decode of registered state, so only the stall gate is combinational.
  assign rd_act       = ((state_q == S_FETCH) || (state_q == S_LOAD)) && (cnt_q != len_q);
  assign st_act       = (state_q == S_STORE);
  assign bus.ram_addr = (rd_act || st_act) ? addr_q[RAM_ADDR_W-1:0] : '0;
  assign bus.ram_wr   = st_act && !stall;
  assign bus.ram_dout = st_act ? wdata_q[7:0] : '0;

  assign lane = cnt_q[1:0] - 2'd1;

  always_comb begin
    rdata_d = rdata_q;
    if (cnt_q != 3'd0) rdata_d[{lane, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
    end else if (bus.ena) begin
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (l_go || f_go) begin
            state_q <= sel_iswrite ? S_STORE : (l_go ? S_LOAD : S_FETCH);
            cnt_q   <= '0;
            len_q   <= size_bytes(sel_size);
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
          end
        end
        S_FETCH, S_LOAD: begin
          if (rb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == len_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (state_q == S_FETCH) begin
              if_ready_q <= 1'b1;
              if_data_q  <= rdata_d;
            end else begin
              ls_ready_q <= 1'b1;
              ls_data_q  <= rdata_d;
            end
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            addr_q  <= addr_q + 32'd1;
            rdata_q <= rdata_d;
          end
        end
        S_STORE: begin
          if (!stall) begin
            if (cnt_q == len_q - 3'd1) begin
              state_q    <= S_IDLE;
              cnt_q      <= '0;
              ls_ready_q <= 1'b1;
              ls_data_q  <= '0;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              addr_q  <= addr_q + 32'd1;
              wdata_q <= wdata_q >> 8;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_if_ready = if_ready_q;
  assign bus.out_if_data  = if_data_q;
  assign bus.out_ls_ready = ls_ready_q;
  assign bus.out_ls_data  = ls_data_q;

endmodule
